sid_bus_arbiter: RTL and testbench
==================================

# sid_bus_arbiter

Write-only bus controller for the external SID chip, running on the 8 MHz board clock. It generates the SID phi2 clock (SID_CLK) and the power-on/soft reset pulse (SID_NOTRES). It arbitrates register writes from two requesters (port 0, e.g. a player sequencer; port 1, e.g. a debug/host port) onto SID_ADDR/SID_DATA/SID_NOTCS, at most one write per phi2 period. It sits between the top-level test logic and the SID pins.

## Interface
- CLK_DIV, 8: board clocks per phi2 period; power of two, ≥4 (8 gives 1 MHz phi2).
- RESET_CYCLES, 16: phi2 periods SID_NOTRES is held low (SID requires ≥10).
- C6_CLK_8MHZ  in  1  board clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ0_VALID  in  1  port 0 write request; hold with stable ADDR/DATA until accepted.
- REQ0_ADDR  in  5  port 0 SID register address.
- REQ0_DATA  in  8  port 0 write data.
- REQ0_READY  out  1  one-cycle accept pulse for port 0.
- REQ1_VALID / REQ1_ADDR / REQ1_DATA / REQ1_READY: same as port 0, for port 1.
- SRST_REQ  in  1  single-cycle soft-reset request for the SID.
- BUSY  out  1  high while the SID is in reset or a soft reset is pending.
- SID_CLK  out  1  phi2 to the SID.
- SID_NOTRES  out  1  SID reset, active low.
- SID_NOTCS  out  1  SID chip select, active low.
- SID_ADDR  out  5  SID address bus.
- SID_DATA  out  8  SID data bus (always driven; no reads).

## Operation
- Phase counter ph: 0..CLK_DIV-1, free-running, wraps to 0. SID_CLK = ph MSB, taken directly from the register bit so it is glitch-free: low for ph < CLK_DIV/2, high otherwise. A "wrap" is the edge from ph=CLK_DIV-1 to ph=0. This edge is the phi2 falling edge, where the SID commits a write.
- State RESET_HOLD: SID_NOTRES=0, no grants, SID_NOTCS=1. The period counter increments on each wrap. At the wrap that completes RESET_CYCLES wraps, SID_NOTRES→1 and the state becomes RUN.
- State RUN: arbitration happens only in ph==0 cycles.
  - If one VALID is high, that port is granted.
  - If both are high, round-robin picks the port not granted last. The pointer resets to favour port 0.
  - The grant asserts the winner's READY for that one cycle (a transfer is VALID&READY). At that edge, SID_ADDR/SID_DATA load the winner's ADDR/DATA and SID_NOTCS→0.
  - CS/ADDR/DATA then hold through ph=1..CLK_DIV-1 and the following ph==0 cycle, giving hold time past the commit wrap.
  - At the edge ending the next ph==0: if a new grant occurs, the new values load and SID_NOTCS stays 0 (back-to-back). Otherwise SID_NOTCS→1, and SID_ADDR/SID_DATA keep their last values.
- READY is never asserted when its VALID is low, in RESET_HOLD, or while a soft reset is pending.
- Soft reset: SRST_REQ sets a pending flag (extra pulses while pending are ignored). At the next ph==0 cycle, pending takes precedence over any grant. At the edge ending that cycle, SID_NOTRES→0, SID_NOTCS→1, the period counter clears, the flag clears, and the state becomes RESET_HOLD. A write whose commit wrap has already occurred is not disturbed.
- BUSY = (state==RESET_HOLD) | pending, registered.
- Requests arriving while BUSY simply wait; nothing is dropped or queued internally.

## Timing
- Reset values (async, on RESET_N=0): ph=0, SID_CLK=0, SID_NOTRES=0, SID_NOTCS=1, SID_ADDR=0, SID_DATA=0, REQ0_READY=REQ1_READY=0, BUSY=1, pending=0, state RESET_HOLD, RR pointer favours port 0.
- Power-on (defaults): SID_NOTRES rises on the 128th rising edge after RESET_N deasserts, which is a wrap. That same edge drops BUSY. The first grant can occur in the ph==0 cycle that follows.
- Soft reset low time: RESET_CYCLES*CLK_DIV-1 clocks (127 with defaults).
- Write latency: VALID seen in a ph==0 cycle → READY in that cycle → SID_NOTCS low 1 clock later → SID commit CLK_DIV-1 clocks after that.
- Worst-case wait from VALID to READY in RUN with the other port saturating: 2*CLK_DIV clocks.
- Throughput: one write per CLK_DIV clocks.
- RESET_N asserted mid-write: everything returns immediately to reset values. The interrupted write is lost, and the SID is reset anyway.

## Test plan
- Power-on: release RESET_N, no requests → SID_CLK toggles with period 8 clocks (4 low/4 high); SID_NOTRES low for exactly 128 clocks; BUSY falls on the same edge; SID_NOTCS stays 1.
- Single write: port 0 VALID, ADDR=0x18, DATA=0x0F after reset → one REQ0_READY pulse in a ph==0 cycle; SID_NOTCS low for exactly 8 clocks spanning one SID_CLK falling edge with SID_ADDR=0x18, SID_DATA=0x0F stable throughout.
- Contention: both ports VALID continuously (port 0 0x00/0x11, port 1 0x01/0x22) → grants alternate 0,1,0,1…; SID_NOTCS stays low continuously; ADDR/DATA change only at ph==1 edges.
- Hold during BUSY: request asserted during the power-on hold → no READY until the first ph==0 after SID_NOTRES rises.
- Soft reset during traffic: SRST_REQ mid-slot while port 1 streams → the in-flight write completes; SID_NOTRES low for 127 clocks; no READY while BUSY; streaming resumes after.
- Async reset mid-write: RESET_N low while SID_NOTCS=0 → same cycle SID_NOTCS=1, SID_NOTRES=0, SID_CLK=0, READY=0.

Source files
------------

// File: rtl/sid_bus_arbiter.sv
// sid_bus_arbiter: write-only SID bus controller. Generates phi2 (SID_CLK),
// the SID reset pulse, and round-robin arbitrates two write ports so that at
// most one register write lands on the SID per phi2 period.
module sid_bus_arbiter #(
    parameter int CLK_DIV      = 8,   // board clocks per phi2 period, power of two >= 4
    parameter int RESET_CYCLES = 16   // phi2 periods SID_NOTRES is held low
) (
    input  logic       C6_CLK_8MHZ,
    input  logic       RESET_N,
    input  logic       REQ0_VALID,
    input  logic [4:0] REQ0_ADDR,
    input  logic [7:0] REQ0_DATA,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic [4:0] REQ1_ADDR,
    input  logic [7:0] REQ1_DATA,
    output logic       REQ1_READY,
    input  logic       SRST_REQ,
    output logic       BUSY,
    output logic       SID_CLK,
    output logic       SID_NOTRES,
    output logic       SID_NOTCS,
    output logic [4:0] SID_ADDR,
    output logic [7:0] SID_DATA
);
    localparam int                PH_W     = $clog2(CLK_DIV);
    localparam int                CNT_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RESET_CYCLES - 1);

    typedef enum logic {
        RESET_HOLD = 1'b0,
        RUN        = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    ph_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               busy_q;
    logic               rr_last_q;      // 1: port 1 won last, so port 0 wins a tie
    logic               cs_n_q;
    logic [4:0]         addr_q;
    logic [7:0]         data_q;

    logic               slot, wrap, arb_en;
    logic [1:0]         valid;
    logic [1:0]         grant;

    assign valid = {REQ1_VALID, REQ0_VALID};

    // Phase counter; wraps naturally because CLK_DIV is a power of two.
    always_ff @(posedge C6_CLK_8MHZ or negedge RESET_N) begin
        if (!RESET_N) ph_q <= '0;
        else          ph_q <= ph_q + 1'b1;
    end

    // Slot decode and round-robin grant; only in ph==0 of RUN with no soft reset waiting.
    always_comb begin
        slot     = (ph_q == '0);
        wrap     = (ph_q == PH_LAST);
        arb_en   = slot && (state_q == RUN) && !pend_q;
        grant[0] = arb_en && valid[0] && (!valid[1] || rr_last_q);
        grant[1] = arb_en && valid[1] && (!valid[0] || !rr_last_q);
    end

    // State, reset-period counter, soft-reset flag and BUSY registers.
    always_ff @(posedge C6_CLK_8MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= RESET_HOLD;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= (state_d == RESET_HOLD) || pend_d;
        end
    end

    // Next state: a pending soft reset fires at the slot and restarts the hold;
    // the hold ends on the wrap that completes RESET_CYCLES phi2 periods.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Pulses while pending are ignored; the flag drops when it fires.
        pend_d  = pend_q ? !slot : SRST_REQ;
        if (slot && pend_q) begin
            state_d = RESET_HOLD;
            cnt_d   = '0;
        end else if ((state_q == RESET_HOLD) && wrap) begin
            if (cnt_q == CNT_LAST) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Bus drive: load on a grant, otherwise release CS at the end of the slot.
    // CS stays low through the commit wrap and the following slot for hold time.
    always_ff @(posedge C6_CLK_8MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            cs_n_q    <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            rr_last_q <= 1'b1;
        end else if (slot) begin
            if (|grant) begin
                cs_n_q    <= 1'b0;
                addr_q    <= grant[1] ? REQ1_ADDR : REQ0_ADDR;
                data_q    <= grant[1] ? REQ1_DATA : REQ0_DATA;
                rr_last_q <= grant[1];
            end else begin
                cs_n_q <= 1'b1;
            end
        end
    end

    assign REQ0_READY = grant[0];
    assign REQ1_READY = grant[1];
    assign BUSY       = busy_q;
    assign SID_CLK    = ph_q[PH_W-1];
    assign SID_NOTRES = (state_q == RUN);
    assign SID_NOTCS  = cs_n_q;
    assign SID_ADDR   = addr_q;
    assign SID_DATA   = data_q;

endmodule

// File: tb/tb_sid_bus_arbiter.sv
// Testbench for sid_bus_arbiter: directed table, hand-written corner sequences,
// and randomized traffic checked every cycle against a time-based reference model.
module tb_sid_bus_arbiter;
    localparam int CD = 8;
    localparam int RC = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v1, rdy0, rdy1, srst, busy, sid_clk, notres, notcs;
    logic [4:0] a0, a1, sid_addr;
    logic [7:0] d0, d1, sid_data;

    int checks = 0;
    int errors = 0;
    int cyc;

    sid_bus_arbiter #(.CLK_DIV(CD), .RESET_CYCLES(RC)) dut (
        .C6_CLK_8MHZ(clk), .RESET_N(rst_n),
        .REQ0_VALID(v0), .REQ0_ADDR(a0), .REQ0_DATA(d0), .REQ0_READY(rdy0),
        .REQ1_VALID(v1), .REQ1_ADDR(a1), .REQ1_DATA(d1), .REQ1_READY(rdy1),
        .SRST_REQ(srst), .BUSY(busy), .SID_CLK(sid_clk), .SID_NOTRES(notres),
        .SID_NOTCS(notcs), .SID_ADDR(sid_addr), .SID_DATA(sid_data)
    );

    always #5 clk = ~clk;

    // Board clock edges since RESET_N released; ph of the current cycle is cyc % CD.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expressed as absolute deadlines in clock edges.
    int         m_hold;   // edge count at which SID_NOTRES goes high
    logic       m_pend, m_last, m_cs_n;
    logic [4:0] m_addr;
    logic [7:0] m_data;

    task automatic model_init();
        m_hold = RC * CD;
        m_pend = 1'b0;
        m_last = 1'b1;
        m_cs_n = 1'b1;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic model_step();
        int   ph;
        logic run, g0, g1;
        ph  = cyc % CD;
        run = (cyc >= m_hold);
        g0  = (ph == 0) && run && !m_pend && v0 && (!v1 || m_last);
        g1  = (ph == 0) && run && !m_pend && v1 && (!v0 || !m_last);
        chk("model_sid_clk", int'(sid_clk), int'(ph >= CD / 2));
        chk("model_notres", int'(notres), int'(run));
        chk("model_busy", int'(busy), int'(!run || m_pend));
        chk("model_ready0", int'(rdy0), int'(g0));
        chk("model_ready1", int'(rdy1), int'(g1));
        chk("model_notcs", int'(notcs), int'(m_cs_n));
        chk("model_addr", int'(sid_addr), int'(m_addr));
        chk("model_data", int'(sid_data), int'(m_data));
        if (ph == 0) begin
            if (m_pend) begin
                m_hold = cyc + RC * CD;   // low from edge cyc+1 for RC*CD-1 clocks
                m_cs_n = 1'b1;
            end else if (g0 || g1) begin
                m_cs_n = 1'b0;
                m_addr = g1 ? a1 : a0;
                m_data = g1 ? d1 : d0;
                m_last = g1;
            end else begin
                m_cs_n = 1'b1;
            end
        end
        m_pend = m_pend ? (ph != 0) : srst;
    endtask

    always @(negedge clk) begin
        if (!rst_n) model_init();
        else        model_step();
    end

    typedef struct {
        logic       v0, v1;
        logic [4:0] a0, a1;
        logic [7:0] d0, d1;
        logic       r0, r1, cs_n;
        logic [4:0] ea;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int early, cs_low, bad, lowcnt, rdy_busy, guard;
        logic acc0, acc1;

        tbl[0] = '{1'b1, 1'b0, 5'h18, 5'h00, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 5'h18, 8'h0F};
        tbl[1] = '{1'b0, 1'b1, 5'h00, 5'h01, 8'h00, 8'h22, 1'b0, 1'b1, 1'b0, 5'h01, 8'h22};
        tbl[2] = '{1'b1, 1'b1, 5'h00, 5'h02, 8'h11, 8'h33, 1'b1, 1'b0, 1'b0, 5'h00, 8'h11};
        tbl[3] = '{1'b1, 1'b1, 5'h03, 5'h02, 8'h44, 8'h33, 1'b0, 1'b1, 1'b0, 5'h02, 8'h33};
        tbl[4] = '{1'b1, 1'b0, 5'h03, 5'h00, 8'h44, 8'h00, 1'b1, 1'b0, 1'b0, 5'h03, 8'h44};
        tbl[5] = '{1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 5'h03, 8'h44};
        tbl[6] = '{1'b0, 1'b1, 5'h00, 5'h1F, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 5'h1F, 8'hFF};
        tbl[7] = '{1'b1, 1'b1, 5'h05, 5'h06, 8'h55, 8'h66, 1'b1, 1'b0, 1'b0, 5'h05, 8'h55};
        tbl[8] = '{1'b1, 1'b1, 5'h07, 5'h06, 8'h77, 8'h66, 1'b0, 1'b1, 1'b0, 5'h06, 8'h66};

        rst_n = 1'b0; srst = 1'b0;
        v0 = 1'b1; a0 = 5'h1A; d0 = 8'hA5;   // a request during reset must not be granted
        v1 = 1'b1; a1 = 5'h05; d1 = 8'h5A;
        repeat (3) tick();

        // Reset values
        chk("rst_sid_clk", int'(sid_clk), 0);
        chk("rst_notres", int'(notres), 0);
        chk("rst_notcs", int'(notcs), 1);
        chk("rst_addr", int'(sid_addr), 0);
        chk("rst_data", int'(sid_data), 0);
        chk("rst_ready0", int'(rdy0), 0);
        chk("rst_ready1", int'(rdy1), 0);
        chk("rst_busy", int'(busy), 1);

        // Power-on hold, request held during BUSY, then the single write
        v0 = 1'b0; v1 = 1'b0;
        rst_n = 1'b1;
        while (cyc < 100) tick();
        v0 = 1'b1; a0 = 5'h18; d0 = 8'h0F;
        early = 0;
        while (cyc < 127) begin
            if (rdy0 || rdy1 || notres) early++;
            tick();
        end
        chk("hold_no_ready", early, 0);
        chk("hold_notres_127", int'(notres), 0);
        chk("hold_busy_127", int'(busy), 1);
        tick();
        chk("poweron_notres_128", int'(notres), 1);
        chk("poweron_busy_128", int'(busy), 0);
        chk("first_grant", int'(rdy0), 1);
        tick();
        v0 = 1'b0;
        cs_low = 0; bad = 0;
        for (int j = 0; j < 12; j++) begin
            if (!notcs) begin
                cs_low++;
                if (sid_addr != 5'h18 || sid_data != 8'h0F) bad++;
            end
            tick();
        end
        chk("single_cs_low_clocks", cs_low, 8);
        chk("single_bus_stable", bad, 0);

        // Table: one entry per arbitration slot, back to back
        for (int i = 0; i < 9; i++) begin
            while (cyc % CD != CD - 1) tick();
            v0 = tbl[i].v0; a0 = tbl[i].a0; d0 = tbl[i].d0;
            v1 = tbl[i].v1; a1 = tbl[i].a1; d1 = tbl[i].d1;
            tick();
            chk($sformatf("tbl%0d_ready0", i), int'(rdy0), int'(tbl[i].r0));
            chk($sformatf("tbl%0d_ready1", i), int'(rdy1), int'(tbl[i].r1));
            tick();
            chk($sformatf("tbl%0d_notcs", i), int'(notcs), int'(tbl[i].cs_n));
            chk($sformatf("tbl%0d_addr", i), int'(sid_addr), int'(tbl[i].ea));
            chk($sformatf("tbl%0d_data", i), int'(sid_data), int'(tbl[i].ed));
        end
        v0 = 1'b0; v1 = 1'b0;

        // Soft reset mid-slot while port 1 streams
        v1 = 1'b1; a1 = 5'h0A; d1 = 8'h5A;
        while (cyc % CD != 0) tick();
        chk("srst_pre_grant", int'(rdy1), 1);
        repeat (3) tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("srst_busy_pending", int'(busy), 1);
        while (cyc % CD != 0) tick();
        chk("srst_precedence", int'(rdy1), 0);
        chk("srst_inflight_hold", int'(notcs), 0);
        tick();
        chk("srst_notres_low", int'(notres), 0);
        chk("srst_notcs_release", int'(notcs), 1);
        lowcnt = 0; rdy_busy = 0; guard = 0;
        while (!notres && guard < 400) begin
            lowcnt++;
            if (rdy0 || rdy1) rdy_busy++;
            tick();
            guard++;
        end
        chk("srst_low_clocks", lowcnt, RC * CD - 1);
        chk("srst_no_ready_busy", rdy_busy, 0);
        chk("srst_resume_ready", int'(rdy1), 1);
        chk("srst_resume_busy", int'(busy), 0);
        tick();
        v1 = 1'b0;

        // Randomized traffic; the model checks every cycle
        acc0 = 1'b0; acc1 = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            acc0 = v0 && rdy0;
            acc1 = v1 && rdy1;
            tick();
            srst = 1'b0;
            if (!v0 || acc0) begin
                v0 = ($urandom_range(0, 3) != 0);
                a0 = 5'($urandom_range(0, 31));
                d0 = 8'($urandom_range(0, 255));
            end
            if (!v1 || acc1) begin
                v1 = ($urandom_range(0, 2) != 0);
                a1 = 5'($urandom_range(0, 31));
                d1 = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 399) == 0) srst = 1'b1;
        end
        srst = 1'b0; v1 = 1'b0;

        // Async reset in the middle of a write, while SID_CLK is high
        v0 = 1'b1; a0 = 5'h15; d0 = 8'h3C;
        guard = 0;
        while (!rdy0 && guard < 400) begin
            tick();
            guard++;
        end
        chk("mw_grant_seen", int'(rdy0), 1);
        repeat (5) tick();
        chk("mw_cs_low", int'(notcs), 0);
        chk("mw_sid_clk_high", int'(sid_clk), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mw_rst_notcs", int'(notcs), 1);
        chk("mw_rst_notres", int'(notres), 0);
        chk("mw_rst_sid_clk", int'(sid_clk), 0);
        chk("mw_rst_ready0", int'(rdy0), 0);
        chk("mw_rst_busy", int'(busy), 1);
        chk("mw_rst_addr", int'(sid_addr), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
